delivery_feed_ctrl: RTL and testbench
=====================================

Name: delivery_feed_ctrl

Overview:
- Upstream feeder for the data delivery subsystem.
- Buffers one tile of eight W-bit payload words written by the host/DMA side: words 0-3 are west lanes 1-4, words 4-7 are north lanes 1-4.
- On start, presents the tile to the delivery subsystem: drives select, the payload word and the 3-bit master read pointer, and advances the pointer on the subsystem's master pointer-update pulse.
- Signals tile completion; supports abort.

Parameters:
W, 32, payload word width
DEPTH, 8, tile buffer entries; fixed at 2**PW
PW, 3, read/write pointer width

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
wr_en  in  1  host write strobe; write accepted when wr_en & wr_ready
wr_data  in  W  host payload word
wr_ready  out  1  buffer can accept a write
start  in  1  single-cycle request to deliver the buffered tile
abort  in  1  single-cycle request to terminate load/run and empty the buffer
master_rptr_en  in  1  pointer-advance pulse from delivery subsystem
select  out  1  delivery enable to subsystem
data  out  W  registered payload word = buffer[rptr]
rptr_out  out  PW  master read pointer to subsystem
busy  out  1  state is RUN or DONE
done  out  1  single-cycle pulse, tile fully delivered
err  out  1  sticky protocol error; cleared by accepted start or reset

Behaviour:
- Reset (async, resetn=0) sets every output and register to its idle value:
  - state=IDLE, wptr=0, count=0, rptr_out=0, data=0, select=0, busy=0, done=0, err=0.
  - wr_ready=1, because the buffer is empty.
  - Buffer contents are not reset; they are don't-care.
- FSM states and transitions:
  - IDLE/LOAD is a single state, IDLE.
    - An accepted write stores buffer[wptr]<=wr_data, then wptr+1 and count+1.
    - wr_ready = (count<8).
    - wr_en while count==8 is ignored and sets err.
  - start in IDLE with count==8:
    - Goes to RUN next cycle: rptr_out=0, select=1, busy=1, err cleared.
    - data=buffer[0] is valid on the same edge that select rises.
  - start in IDLE with count<8 is ignored, sets err, and leaves state unchanged.
  - RUN:
    - Each master_rptr_en advances the pointer: rptr_out<=rptr_out+1 (mod 8), data<=buffer[rptr_out+1] in the same edge.
    - Latency is 1 cycle from master_rptr_en to the new rptr_out/data.
    - Advance counter adv counts 0..7.
    - On the master_rptr_en with adv==7: rptr_out wraps to 0, go to DONE.
    - wr_ready=0 throughout. wr_en is ignored and sets err. start is ignored; it does not set err.
  - DONE (exactly 1 cycle):
    - done=1, select=0.
    - count<=0, wptr<=0, rptr_out=0, data=0.
    - Next state IDLE with wr_ready=1.
- master_rptr_en outside RUN is ignored and sets err.
- abort in any state:
  - Next cycle: IDLE, count=0, wptr=0, rptr_out=0, select=0, data=0, busy=0.
  - No done pulse; err unchanged.
  - abort has priority over start, wr_en and master_rptr_en in the same cycle.
- Simultaneous events:
  - wr_en and start in the same IDLE cycle with count==7: the write is taken, start is evaluated against the pre-write count (7), so start is ignored and err is set.
  - The last master_rptr_en plus a new wr_en in the same cycle: the write is rejected (still RUN) and err is set.
- Reset mid-RUN drops select immediately (async) and discards the tile.
- All outputs are registered; no combinational path from inputs to outputs except wr_ready, which is derived from registered count and state.

Test Plan:
- Load 0x11111111..0x88888888 (8 writes), pulse start → next cycle select=1, rptr_out=0, data=0x11111111. Each of 8 master_rptr_en pulses (spaced 3 cycles) → rptr_out 1..7, data 0x22222222..0x88888888. Then a 1-cycle done=1, select=0, rptr_out=0, wr_ready=1.
- Back-to-back master_rptr_en for 8 cycles → rptr_out increments every cycle, done asserts in the cycle after the 8th pulse, busy deasserts 1 cycle later.
- Write 5 words, pulse start → state stays IDLE, select=0, err=1. Write 3 more, start → RUN, err=0.
- Write a 9th word with count==8 → wr_data not stored, wr_ready=0, err=1. The first word is still delivered as 0x11111111.
- abort during RUN at rptr_out=4 → next cycle select=0, rptr_out=0, busy=0, wr_ready=1, no done. A fresh 8-word load and start delivers the new tile from rptr_out=0.
- Assert resetn=0 mid-RUN (asynchronously, between edges) → select, busy, data, rptr_out go to 0 immediately. Also: master_rptr_en in IDLE → rptr_out stays 0, err=1.

Source files
------------

// File: rtl/delivery_feed_if.sv
// Handshake and delivery bus between the host/DMA side, the feeder and the
// delivery subsystem. The master modport is the host/subsystem side; the
// feeder itself connects through the slave modport.
interface delivery_feed_if #(
  parameter int W  = 32,
  parameter int PW = 3
) ();
  logic          wr_en;
  logic [W-1:0]  wr_data;
  logic          wr_ready;
  logic          start;
  logic          abort;
  logic          master_rptr_en;
  logic          select;
  logic [W-1:0]  data;
  logic [PW-1:0] rptr_out;
  logic          busy;
  logic          done;
  logic          err;

  modport master (
    output wr_en, wr_data, start, abort, master_rptr_en,
    input  wr_ready, select, data, rptr_out, busy, done, err
  );

  modport slave (
    input  wr_en, wr_data, start, abort, master_rptr_en,
    output wr_ready, select, data, rptr_out, busy, done, err
  );
endinterface

// File: rtl/delivery_feed_ctrl.sv
// Tile feeder: buffers eight payload words (west lanes 1-4, north lanes 1-4),
// then presents them to the delivery subsystem one word per pointer-update
// pulse, signalling completion with a single-cycle done.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | loading; accepts host writes until the tile is full
// RUN   | tile presented, select high, pointer advances on rptr pulse
// DONE  | one-cycle completion pulse, buffer marked empty
module delivery_feed_ctrl #(
  parameter int W     = 32,
  parameter int PW    = 3,
  parameter int DEPTH = 2 ** PW
) (
  input  logic             clk,
  input  logic             resetn,
  delivery_feed_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  state_t        state_q;
  logic [W-1:0]  buf_q [DEPTH];
  logic [PW-1:0] wptr_q;
  logic [PW-1:0] rptr_q;
  logic [PW-1:0] adv_q;
  logic [PW:0]   count_q;
  logic [W-1:0]  data_q;
  logic          select_q;
  logic          busy_q;
  logic          done_q;
  logic          err_q;

  logic          wr_ready_d;
  logic          wr_accept_d;
  logic          start_ok_d;
  logic          adv_ok_d;
  logic          err_set_d;
  logic [PW-1:0] rptr_inc_d;

  // The buffer is writable whenever the tile is not being delivered; DONE
  // already sees an emptied buffer so the host can refill without a bubble.
  assign wr_ready_d  = (state_q != RUN) && (count_q < FULL);
  assign wr_accept_d = bus.wr_en && wr_ready_d && !bus.abort;
  // start is judged against the count before any same-cycle write lands.
  assign start_ok_d  = bus.start && !bus.abort && (state_q == IDLE) && (count_q == FULL);
  assign adv_ok_d    = bus.master_rptr_en && !bus.abort && (state_q == RUN);
  assign rptr_inc_d  = rptr_q + 1'b1;
  // abort wins over everything, so it never raises a protocol error.
  assign err_set_d   = !bus.abort &&
                       ((bus.wr_en && !wr_ready_d) ||
                        (bus.master_rptr_en && (state_q != RUN)) ||
                        (bus.start && (state_q == IDLE) && (count_q != FULL)));

  // Tile storage; contents are don't-care after reset so no reset branch.
  always_ff @(posedge clk) begin
    if (wr_accept_d) begin
      buf_q[wptr_q] <= bus.wr_data;
    end
  end

  // Control FSM with registered delivery outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      wptr_q   <= '0;
      count_q  <= '0;
      rptr_q   <= '0;
      adv_q    <= '0;
      data_q   <= '0;
      select_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= (err_q && !start_ok_d) || err_set_d;
      if (bus.abort) begin
        state_q  <= IDLE;
        wptr_q   <= '0;
        count_q  <= '0;
        rptr_q   <= '0;
        adv_q    <= '0;
        data_q   <= '0;
        select_q <= 1'b0;
        busy_q   <= 1'b0;
      end else begin
        if (wr_accept_d) begin
          wptr_q  <= wptr_q + 1'b1;
          count_q <= count_q + 1'b1;
        end
        case (state_q)
          IDLE: begin
            if (start_ok_d) begin
              state_q  <= RUN;
              rptr_q   <= '0;
              adv_q    <= '0;
              data_q   <= buf_q[0];
              select_q <= 1'b1;
              busy_q   <= 1'b1;
            end
          end
          RUN: begin
            if (adv_ok_d) begin
              if (adv_q == '1) begin
                state_q  <= DONE;
                rptr_q   <= '0;
                adv_q    <= '0;
                data_q   <= '0;
                select_q <= 1'b0;
                done_q   <= 1'b1;
                count_q  <= '0;
                wptr_q   <= '0;
              end else begin
                rptr_q <= rptr_inc_d;
                data_q <= buf_q[rptr_inc_d];
                adv_q  <= adv_q + 1'b1;
              end
            end
          end
          DONE: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign bus.wr_ready = wr_ready_d;
  assign bus.select   = select_q;
  assign bus.data     = data_q;
  assign bus.rptr_out = rptr_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;

endmodule

// File: tb/tb_delivery_feed_ctrl.sv
// Directed bench for the tile feeder: load/deliver, back-to-back advance,
// short-tile start, overfill, abort, async reset and stray pointer pulses.
module tb_delivery_feed_ctrl;

  logic clk;
  logic resetn;
  int   n_cmp;
  int   n_bad;

  delivery_feed_if #(.W(32), .PW(3)) bus ();

  delivery_feed_ctrl #(.W(32), .PW(3)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] pat(input int i);
    return 32'(i + 1) * 32'h1111_1111;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_data = d;
    tick();
    bus.wr_en   = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic pulse_adv();
    bus.master_rptr_en = 1'b1;
    tick();
    bus.master_rptr_en = 1'b0;
  endtask

  task automatic pulse_abort();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    resetn             = 1'b0;
    bus.wr_en          = 1'b0;
    bus.wr_data        = '0;
    bus.start          = 1'b0;
    bus.abort          = 1'b0;
    bus.master_rptr_en = 1'b0;
    repeat (3) tick();
    resetn = 1'b1;
    tick();

    // reset state
    chk("rst_select",   bus.select,   0);
    chk("rst_rptr",     bus.rptr_out, 0);
    chk("rst_data",     bus.data,     0);
    chk("rst_busy",     bus.busy,     0);
    chk("rst_done",     bus.done,     0);
    chk("rst_err",      bus.err,      0);
    chk("rst_wr_ready", bus.wr_ready, 1);

    // full tile, pulses spaced three cycles apart
    for (int i = 0; i < 8; i++) wr(pat(i));
    chk("full_wr_ready", bus.wr_ready, 0);
    chk("full_err",      bus.err,      0);
    pulse_start();
    chk("run_select", bus.select,   1);
    chk("run_rptr0",  bus.rptr_out, 0);
    chk("run_data0",  bus.data,     32'h1111_1111);
    chk("run_busy",   bus.busy,     1);
    for (int k = 1; k < 8; k++) begin
      pulse_adv();
      chk("adv_rptr", bus.rptr_out, 32'(k));
      chk("adv_data", bus.data,     pat(k));
      if (k == 3) pulse_start(); else tick();
      tick();
    end
    chk("run_start_no_err", bus.err,      0);
    chk("run_rptr_hold",    bus.rptr_out, 7);
    pulse_adv();
    chk("done_pulse",    bus.done,     1);
    chk("done_select",   bus.select,   0);
    chk("done_rptr",     bus.rptr_out, 0);
    chk("done_data",     bus.data,     0);
    chk("done_wr_ready", bus.wr_ready, 1);
    chk("done_busy",     bus.busy,     1);
    tick();
    chk("post_done",     bus.done,     0);
    chk("post_busy",     bus.busy,     0);

    // back-to-back pointer pulses
    for (int i = 0; i < 8; i++) wr(32'hA000_0000 + 32'(i));
    pulse_start();
    chk("b2b_data0", bus.data, 32'hA000_0000);
    bus.master_rptr_en = 1'b1;
    for (int k = 0; k < 7; k++) begin
      tick();
      chk("b2b_rptr", bus.rptr_out, 32'(k + 1));
      chk("b2b_data", bus.data,     32'hA000_0000 + 32'(k + 1));
      chk("b2b_done", bus.done,     0);
    end
    tick();
    bus.master_rptr_en = 1'b0;
    chk("b2b_done_pulse", bus.done,     1);
    chk("b2b_rptr_wrap",  bus.rptr_out, 0);
    chk("b2b_busy_done",  bus.busy,     1);
    tick();
    chk("b2b_busy_off",   bus.busy,     0);
    chk("b2b_err",        bus.err,      0);

    // short tile start, then complete and abort at rptr 4
    for (int i = 0; i < 5; i++) wr(32'hB000_0000 + 32'(i));
    pulse_start();
    chk("short_select",   bus.select,   0);
    chk("short_busy",     bus.busy,     0);
    chk("short_err",      bus.err,      1);
    chk("short_wr_ready", bus.wr_ready, 1);
    for (int i = 5; i < 8; i++) wr(32'hB000_0000 + 32'(i));
    pulse_start();
    chk("short_run_sel",  bus.select,   1);
    chk("short_run_err",  bus.err,      0);
    chk("short_run_data", bus.data,     32'hB000_0000);
    repeat (4) pulse_adv();
    chk("pre_abort_rptr", bus.rptr_out, 4);
    chk("pre_abort_data", bus.data,     32'hB000_0004);
    pulse_abort();
    chk("abort_select",   bus.select,   0);
    chk("abort_rptr",     bus.rptr_out, 0);
    chk("abort_busy",     bus.busy,     0);
    chk("abort_data",     bus.data,     0);
    chk("abort_wr_ready", bus.wr_ready, 1);
    chk("abort_done",     bus.done,     0);
    tick();
    chk("abort_done2",    bus.done,     0);
    chk("abort_err",      bus.err,      0);
    for (int i = 0; i < 8; i++) wr(32'hC000_0000 + 32'(i));
    pulse_start();
    chk("fresh_rptr", bus.rptr_out, 0);
    chk("fresh_data", bus.data,     32'hC000_0000);
    pulse_adv();
    chk("fresh_data1", bus.data, 32'hC000_0001);
    pulse_abort();

    // overfill: 9th word dropped
    for (int i = 0; i < 8; i++) wr(pat(i));
    wr(32'hDEAD_BEEF);
    chk("ovf_err",      bus.err,      1);
    chk("ovf_wr_ready", bus.wr_ready, 0);
    pulse_start();
    chk("ovf_data0",    bus.data,     32'h1111_1111);
    chk("ovf_err_clr",  bus.err,      0);
    pulse_abort();

    // write and start together at count 7
    for (int i = 0; i < 7; i++) wr(32'hD000_0000 + 32'(i));
    bus.wr_en   = 1'b1;
    bus.wr_data = 32'hD000_0007;
    bus.start   = 1'b1;
    tick();
    bus.wr_en   = 1'b0;
    bus.start   = 1'b0;
    chk("ws_select",   bus.select,   0);
    chk("ws_err",      bus.err,      1);
    chk("ws_wr_ready", bus.wr_ready, 0);
    pulse_start();
    chk("ws_run",      bus.select,   1);
    repeat (7) pulse_adv();
    chk("ws_last",     bus.data,     32'hD000_0007);

    // last pulse with a write in the same cycle
    bus.master_rptr_en = 1'b1;
    bus.wr_en          = 1'b1;
    bus.wr_data        = 32'hEEEE_EEEE;
    tick();
    bus.master_rptr_en = 1'b0;
    bus.wr_en          = 1'b0;
    chk("lw_done", bus.done, 1);
    chk("lw_err",  bus.err,  1);
    tick();
    chk("lw_wr_ready", bus.wr_ready, 1);

    // async reset mid-run
    for (int i = 0; i < 8; i++) wr(pat(i));
    pulse_start();
    repeat (2) pulse_adv();
    chk("pre_rst_rptr", bus.rptr_out, 2);
    #3;
    resetn = 1'b0;
    #1;
    chk("arst_select", bus.select,   0);
    chk("arst_busy",   bus.busy,     0);
    chk("arst_data",   bus.data,     0);
    chk("arst_rptr",   bus.rptr_out, 0);
    #2;
    resetn = 1'b1;
    tick();

    // stray pointer pulse in IDLE
    pulse_adv();
    chk("idle_adv_rptr", bus.rptr_out, 0);
    chk("idle_adv_err",  bus.err,      1);
    chk("idle_adv_sel",  bus.select,   0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
